// File: rtl/ct_merge_sched.sv
// ---------------------------------------------------------------------------
// ct_merge_sched
//   Packet-aware weighted round-robin scheduler for an NI-input merge
//   datapath. One input owns the merge at a time and keeps it for whole
//   packets. On each turn it may send up to its weight of back-to-back
//   packets. Every change of owner passes through exactly one IDLE cycle.
//
// Ports
//   clk        clock
//   reset_n    asynchronous active-low reset
//   i_valid    per-input valid                          [NI]
//   i_eop      per-input end-of-packet, qualified by valid [NI]
//   i_ready    downstream ready
//   i_weight   per-input packet quota, WBITS each; 0 disables the input
//   o_grant    one-hot owner while a grant is held      (registered)
//   o_sel      encoded owner for the merge mux          (registered)
//   o_ready    per-input ready = i_ready & o_grant
//   o_valid    o_active & i_valid[owner]
//   o_active   high while a grant is held               (registered)
//   o_timeout  one-cycle stall watchdog pulse           (registered)
//
// Optional feature
//   CT_SCHED_WATCHDOG_EN : when defined, an owner that keeps valid low in
//   mid-packet for TIMEOUT cycles loses its grant, and o_timeout pulses.
//   When it is not defined, o_timeout is tied to 0 and a stalled owner
//   keeps the grant.
// ---------------------------------------------------------------------------
module ct_merge_sched #(
    parameter  int NI      = 2,
    parameter  int WBITS   = 4,
    parameter  int TIMEOUT = 255,
    localparam int NIBITS  = (NI > 1) ? $clog2(NI) : 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NI-1:0]       i_valid,
    input  logic [NI-1:0]       i_eop,
    input  logic                i_ready,
    input  logic [NI*WBITS-1:0] i_weight,
    output logic [NI-1:0]       o_grant,
    output logic [NIBITS-1:0]   o_sel,
    output logic [NI-1:0]       o_ready,
    output logic                o_valid,
    output logic                o_active,
    output logic                o_timeout
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PKT  = 2'd1,
        ST_BND  = 2'd2
    } state_e;

    state_e              state_q;
    logic [NIBITS-1:0]   owner_q;
    logic [NIBITS-1:0]   last_q;
    logic [NIBITS-1:0]   sel_q;
    logic [WBITS-1:0]    quota_q;
    logic [WBITS-1:0]    quota_d;
    logic [NI-1:0]       grant_q;
    logic                active_q;

    logic [WBITS-1:0]    weight_s [NI];
    logic [NI-1:0]       elig_s;
    logic [NIBITS-1:0]   pick_s;
    logic [NIBITS-1:0]   scan_s;
    logic                pick_found_s;
    logic                owner_valid_s;
    logic                owner_eop_s;
    logic                xfer_s;
    logic                held_s;
    logic                rel_s;
    logic                to_bnd_s;
    logic                to_pkt_s;
    logic                wd_rel_s;

    function automatic logic [NI-1:0] onehot_f(input logic [NIBITS-1:0] idx);
        logic [NI-1:0] one;
        one      = '0;
        one[0]   = 1'b1;
        onehot_f = one << idx;
    endfunction

    // An input with weight zero is never eligible, whatever its valid says.
    for (genvar g = 0; g < NI; g++) begin : g_in
        assign weight_s[g] = i_weight[g*WBITS +: WBITS];
        assign elig_s[g]   = i_valid[g] & (|weight_s[g]);
    end

    assign owner_valid_s = i_valid[owner_q];
    assign owner_eop_s   = i_eop[owner_q];
    assign o_valid       = active_q & owner_valid_s;
    assign xfer_s        = o_valid & i_ready;
    assign o_ready       = grant_q & {NI{i_ready}};
    assign o_grant       = grant_q;
    assign o_sel         = sel_q;
    assign o_active      = active_q;
    assign quota_d       = quota_q - WBITS'(1);
    assign held_s        = (state_q == ST_PKT) || (state_q == ST_BND);

    // Round-robin pick: first eligible input after the last released owner.
    always_comb begin
        pick_found_s = 1'b0;
        pick_s       = '0;
        scan_s       = '0;
        for (int k = 1; k <= NI; k++) begin
            scan_s = NIBITS'((int'(last_q) + k) % NI);
            if (!pick_found_s && elig_s[scan_s]) begin
                pick_found_s = 1'b1;
                pick_s       = scan_s;
            end else begin
                // an earlier hit in scan order already wins
            end
        end
    end

    // Decode what the owner's handshake does to a held grant this cycle.
    always_comb begin
        rel_s    = 1'b0;
        to_bnd_s = 1'b0;
        to_pkt_s = 1'b0;
        if (held_s) begin
            if (owner_valid_s) begin
                if (xfer_s && owner_eop_s) begin
                    // the decremented quota decides between another packet and release
                    if (quota_d == '0) begin
                        rel_s = 1'b1;
                    end else begin
                        to_bnd_s = 1'b1;
                    end
                end else if (xfer_s) begin
                    to_pkt_s = 1'b1;
                end else begin
                    // backpressure: nothing moves
                end
            end else if (state_q == ST_BND) begin
                // owner has nothing more to send between packets
                rel_s = 1'b1;
            end else begin
                rel_s = wd_rel_s;
            end
        end else begin
            rel_s = 1'b0;
        end
    end

`ifdef CT_SCHED_WATCHDOG_EN
    localparam int TBITS = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TBITS-1:0] STALL_LAST = TBITS'(TIMEOUT - 1);

    logic [TBITS-1:0] stall_q;
    logic             timeout_q;

    // The cycle that would bring the stall count to TIMEOUT releases the grant.
    assign wd_rel_s  = (state_q == ST_PKT) && !owner_valid_s && (stall_q == STALL_LAST);
    assign o_timeout = timeout_q;

    // Stall counter: only owner-valid-low cycles in PKT count, never backpressure.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= wd_rel_s;
            if (wd_rel_s) begin
                stall_q <= '0;
            end else if ((state_q == ST_PKT) && !owner_valid_s) begin
                stall_q <= stall_q + TBITS'(1);
            end else begin
                stall_q <= '0;
            end
        end
    end
`else
    assign wd_rel_s  = 1'b0;
    assign o_timeout = 1'b0;
`endif

    // Scheduler FSM with registered grant, select and active outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            owner_q  <= '0;
            quota_q  <= '0;
            last_q   <= NIBITS'(NI - 1);
            grant_q  <= '0;
            sel_q    <= '0;
            active_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_found_s) begin
                        // weight is sampled only here, once per turn
                        state_q  <= ST_PKT;
                        owner_q  <= pick_s;
                        quota_q  <= weight_s[pick_s];
                        grant_q  <= onehot_f(pick_s);
                        sel_q    <= pick_s;
                        active_q <= 1'b1;
                    end else begin
                        state_q  <= ST_IDLE;
                    end
                end
                ST_PKT, ST_BND: begin
                    if (rel_s) begin
                        state_q  <= ST_IDLE;
                        last_q   <= owner_q;
                        quota_q  <= '0;
                        grant_q  <= '0;
                        sel_q    <= '0;
                        active_q <= 1'b0;
                    end else if (to_bnd_s) begin
                        state_q  <= ST_BND;
                        quota_q  <= quota_d;
                    end else if (to_pkt_s) begin
                        state_q  <= ST_PKT;
                    end else begin
                        state_q  <= state_q;
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    grant_q  <= '0;
                    sel_q    <= '0;
                    active_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ct_merge_sched.sv
// Self-checking bench for ct_merge_sched (NI=3, WBITS=4, TIMEOUT=8).
// The reference model tracks the current turn as owner / packets left /
// packets done / mid-packet flag and is compared against the DUT on every
// negative clock edge; directed scenarios add literal expectations.
module tb_ct_merge_sched;
    localparam int NI = 3;
    localparam int WB = 4;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [NI-1:0] i_valid, i_eop;
    logic          i_ready;
    logic [NI*WB-1:0] i_weight;
    logic [NI-1:0] o_grant, o_ready;
    logic [1:0]    o_sel;
    logic          o_valid, o_active, o_timeout;

    always #5 clk = ~clk;

    ct_merge_sched #(.NI(NI), .WBITS(WB), .TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n), .i_valid(i_valid), .i_eop(i_eop),
        .i_ready(i_ready), .i_weight(i_weight), .o_grant(o_grant), .o_sel(o_sel),
        .o_ready(o_ready), .o_valid(o_valid), .o_active(o_active), .o_timeout(o_timeout));

    int n_cmp = 0;
    int n_bad = 0;

    // reference model of the current turn
    int m_owner, m_left, m_done, m_last, m_stall, m_xfer_i;
    bit m_mid, m_to;
    logic [3:0] wt [NI];

    // packet sources
    int len [NI];
    int beat [NI];
    int plen_min = 2, plen_max = 2;

    int pkt_log [$];
    int saw_g2;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit vbit(input int i);
        return i_valid[i[1:0]];
    endfunction

    function automatic bit ebit(input int i);
        return i_eop[i[1:0]];
    endfunction

    function automatic void model_reset();
        m_owner = -1; m_left = 0; m_done = 0; m_mid = 1'b0;
        m_last = NI - 1; m_stall = 0; m_to = 1'b0; m_xfer_i = -1;
    endfunction

    // advance the model by one clock using the inputs seen at that edge
    function automatic void model_step();
        int o;
        m_to = 1'b0;
        m_xfer_i = -1;
        if (!reset_n) begin
            model_reset();
            return;
        end
        if (m_owner < 0) begin
            for (int k = 1; k <= NI; k++) begin
                int i;
                i = (m_last + k) % NI;
                if (vbit(i) && wt[i] != 4'd0) begin
                    m_owner = i; m_left = int'(wt[i]); m_done = 0; m_mid = 1'b0; m_stall = 0;
                    break;
                end
            end
        end else begin
            o = m_owner;
            if (vbit(o)) begin
                m_stall = 0;
                if (i_ready) begin
                    m_xfer_i = o;
                    if (ebit(o)) begin
                        m_left--; m_done++; m_mid = 1'b0;
                        if (m_left == 0) begin m_last = o; m_owner = -1; end
                    end else begin
                        m_mid = 1'b1;
                    end
                end
            end else if (m_done > 0 && !m_mid) begin
                m_last = o; m_owner = -1;
            end else begin
`ifdef CT_SCHED_WATCHDOG_EN
                m_stall++;
                if (m_stall == TO) begin
                    m_to = 1'b1; m_last = o; m_owner = -1; m_stall = 0;
                end
`endif
            end
        end
    endfunction

    // single compare process: DUT against model on every falling edge
    logic [NI-1:0] eg;
    bit ev;
    always @(negedge clk) begin
        eg = (m_owner >= 0) ? 3'(3'b001 << m_owner) : 3'b000;
        ev = 1'b0;
        if (m_owner >= 0) ev = vbit(m_owner);
        chk("grant", int'(o_grant), int'(eg));
        chk("sel", int'(o_sel), (m_owner >= 0) ? m_owner : 0);
        chk("active", int'(o_active), (m_owner >= 0) ? 1 : 0);
        chk("valid", int'(o_valid), int'(ev));
        chk("ready", int'(o_ready), i_ready ? int'(eg) : 0);
        chk("timeout", int'(o_timeout), int'(m_to));
        if (o_valid && i_ready && i_eop[o_sel]) pkt_log.push_back(int'(o_sel));
        if (o_grant[2]) saw_g2++;
    end

    task automatic set_w(input int a, input int b, input int c);
        wt[0] = 4'(a); wt[1] = 4'(b); wt[2] = 4'(c);
        i_weight = {wt[2], wt[1], wt[0]};
    endtask

    // move sources on completed beats, then drive next-cycle inputs
    task automatic src_drive(input int vmode, input int rmode);
        if (m_xfer_i >= 0) begin
            beat[m_xfer_i]++;
            if (beat[m_xfer_i] >= len[m_xfer_i]) begin
                beat[m_xfer_i] = 0;
                len[m_xfer_i] = $urandom_range(plen_max, plen_min);
            end
        end
        for (int s = 0; s < NI; s++) begin
            i_valid[s] = (vmode == 0) ? 1'b1 : ($urandom_range(0, 9) < 8);
            i_eop[s]   = (beat[s] == len[s] - 1);
        end
        i_ready = (rmode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic run(input int n, input int vmode, input int rmode);
        repeat (n) begin
            step();
            src_drive(vmode, rmode);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        model_reset();
        for (int s = 0; s < NI; s++) begin
            beat[s] = 0;
            len[s] = $urandom_range(plen_max, plen_min);
        end
        src_drive(0, 0);
        pkt_log.delete();
        saw_g2 = 0;
        repeat (2) @(posedge clk);
    endtask

    task automatic release_rst();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    int held_bad, to_cnt, g1_cnt, lead;

    initial begin
        reset_n = 1'b0;
        i_valid = '0; i_eop = '0; i_ready = 1'b1;
        set_w(1, 1, 1);
        model_reset();
        for (int s = 0; s < NI; s++) begin beat[s] = 0; len[s] = 2; end

        // reset and first grant, then equal weights with 2-beat packets
        plen_min = 2; plen_max = 2;
        do_reset();
        @(negedge clk);
        chk("rst_grant", int'(o_grant), 0);
        chk("rst_sel", int'(o_sel), 0);
        chk("rst_active", int'(o_active), 0);
        chk("rst_oready", int'(o_ready), 0);
        chk("rst_ovalid", int'(o_valid), 0);
        release_rst();
        step();
        src_drive(0, 0);
        @(negedge clk);
        chk("first_grant", int'(o_grant), 1);
        chk("first_sel", int'(o_sel), 0);
        run(16, 0, 0);
        chk("eq_npkts", (pkt_log.size() >= 5) ? 1 : 0, 1);
        if (pkt_log.size() >= 5) begin
            chk("eq_p0", pkt_log[0], 0); chk("eq_p1", pkt_log[1], 1);
            chk("eq_p2", pkt_log[2], 2); chk("eq_p3", pkt_log[3], 0);
            chk("eq_p4", pkt_log[4], 1);
        end

        // weighted turn 1/2/1
        set_w(1, 2, 1);
        do_reset();
        release_rst();
        run(20, 0, 0);
        chk("wt_npkts", (pkt_log.size() >= 5) ? 1 : 0, 1);
        if (pkt_log.size() >= 5) begin
            chk("wt_p0", pkt_log[0], 0); chk("wt_p1", pkt_log[1], 1);
            chk("wt_p2", pkt_log[2], 1); chk("wt_p3", pkt_log[3], 2);
            chk("wt_p4", pkt_log[4], 0);
        end

        // disabled input 2, variable packet lengths
        plen_min = 1; plen_max = 3;
        set_w(1, 1, 0);
        do_reset();
        release_rst();
        run(90, 0, 0);
        chk("dis_g2", saw_g2, 0);
        chk("dis_npkts", (pkt_log.size() >= 20) ? 1 : 0, 1);
        for (int k = 0; k < 20 && k < pkt_log.size(); k++) chk("dis_alt", pkt_log[k], k % 2);

        // early release after one single-beat packet
        set_w(3, 1, 1);
        do_reset();
        i_valid = 3'b011; i_eop = 3'b011;
        release_rst();
        step();
        @(negedge clk);
        chk("er_pkt", int'(o_grant), 1);
        step();
        i_valid = 3'b010;
        @(negedge clk);
        chk("er_bnd_grant", int'(o_grant), 1);
        chk("er_bnd_ready", int'(o_ready), 1);
        step();
        @(negedge clk);
        chk("er_idle", int'(o_grant), 0);
        step();
        @(negedge clk);
        chk("er_next", int'(o_grant), 2);

        // backpressure mid-packet
        plen_min = 4; plen_max = 4;
        set_w(1, 1, 1);
        do_reset();
        release_rst();
        run(2, 0, 0);
        i_ready = 1'b0;
        held_bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (o_grant !== 3'b001 || o_ready !== 3'b000) held_bad++;
            step();
            src_drive(0, 0);
            i_ready = 1'b0;
        end
        i_ready = 1'b1;
        chk("bp_held", held_bad, 0);
        chk("bp_nopkt", pkt_log.size(), 0);
        run(8, 0, 0);
        chk("bp_resume", (pkt_log.size() >= 1) ? pkt_log[0] : -1, 0);

        // owner stalls with valid low mid-packet
        set_w(1, 1, 1);
        do_reset();
        i_valid = 3'b011; i_eop = 3'b000;
        release_rst();
        step();
        step();
        i_valid = 3'b010;
        to_cnt = 0; g1_cnt = 0;
        repeat (12) begin
            step();
            @(negedge clk);
            if (o_timeout) to_cnt++;
            if (o_grant[1]) g1_cnt++;
        end
`ifdef CT_SCHED_WATCHDOG_EN
        chk("wd_pulses", to_cnt, 1);
        chk("wd_regrant", (g1_cnt > 0) ? 1 : 0, 1);
`else
        chk("wd_pulses", to_cnt, 0);
        chk("wd_held", int'(o_grant), 1);
`endif

        // full-scale weight gives 15 packets in one turn
        plen_min = 1; plen_max = 1;
        set_w(15, 1, 1);
        do_reset();
        release_rst();
        run(40, 0, 0);
        lead = 0;
        for (int k = 0; k < pkt_log.size(); k++) begin
            if (pkt_log[k] == 0) lead++;
            else break;
        end
        chk("w15_turn", lead, 15);

        // randomized traffic, weights, backpressure and occasional resets
        plen_min = 1; plen_max = 4;
        do_reset();
        release_rst();
        for (int blk = 0; blk < 40; blk++) begin
            set_w(($urandom_range(0, 9) == 0) ? 15 : $urandom_range(0, 4),
                  $urandom_range(0, 4), $urandom_range(0, 4));
            if ($urandom_range(0, 7) == 0) begin
                do_reset();
                release_rst();
            end
            run(60, 1, 1);
        end

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
